// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit datapath: decodes the IR opcode, sequences memory
// handshakes and drives the datapath mux selects. Optional retire counter: CTRL_RETIRE_CNT_EN.
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15
`ifdef CTRL_RETIRE_CNT_EN
  , parameter int RETIRE_W = 16
`endif
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] opcode,
  input  logic       zeroFlag,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       regWrite,
  output logic [1:0] pcSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] regDataSlct,
  output logic [2:0] aluOp,
  output logic       busErr,
  output logic       illegalOp
`ifdef CTRL_RETIRE_CNT_EN
  , output logic [RETIRE_W-1:0] retireCnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_J    = 4'h6;
  localparam logic [3:0] OP_JAL  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                bus_err_q, bus_err_d;
  logic                wait_state;
  logic                timeout;

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout    = wait_state && !memReady && (wait_cnt_q == WCNT_W'(WAIT_LIMIT - 1));
  assign busErr     = bus_err_q;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    bus_err_d   = bus_err_q;
    pcWrite     = 1'b0;
    irWrite     = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    regWrite    = 1'b0;
    pcSrc       = 2'b00;
    aluSrcA     = 2'b00;
    aluSrcB     = 2'b00;
    regDataSlct = 2'b00;
    aluOp       = 3'b000;
    illegalOp   = 1'b0;

    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        case (opcode)
          OP_R:           state_d = S_EXEC_R;
          OP_ADDI:        state_d = S_EXEC_I;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J, OP_JAL:   state_d = S_JUMP;
          OP_HALT:        state_d = S_HALT;
          default: begin
            illegalOp = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        aluSrcA = 2'b01;
        aluOp   = 3'b010;
        state_d = S_WB_R;
      end
      S_EXEC_I: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        regWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_ADDR: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        memRead = 1'b1;
        if (memReady) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        regWrite    = 1'b1;
        regDataSlct = 2'b01;
        state_d     = S_FETCH;
      end
      S_MEM_WR: begin
        memWrite = 1'b1;
        if (memReady) state_d = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA = 2'b01;
        aluOp   = 3'b001;
        pcSrc   = 2'b01;
        pcWrite = (opcode == OP_BNE) ? !zeroFlag : zeroFlag;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcWrite = 1'b1;
        pcSrc   = 2'b10;
        if (opcode == OP_JAL) begin
          regWrite    = 1'b1;
          regDataSlct = 2'b10;
        end
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Stalled access: count, and give up with a sticky bus error once the limit is hit.
    if (wait_state && !memReady) begin
      if (timeout) begin
        bus_err_d = 1'b1;
        state_d   = S_HALT;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end

    // Strobes must fall the instant reset asserts, even though FETCH is a requesting state.
    if (!resetN) begin
      pcWrite     = 1'b0;
      irWrite     = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      regWrite    = 1'b0;
      pcSrc       = 2'b00;
      aluSrcA     = 2'b00;
      aluSrcB     = 2'b00;
      regDataSlct = 2'b00;
      aluOp       = 3'b000;
      illegalOp   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] retire_q;
  logic                retire_evt;

  assign retire_evt = (state_d == S_FETCH) &&
                      ((state_q == S_WB_R) || (state_q == S_WB_MEM) || (state_q == S_MEM_WR) ||
                       (state_q == S_BRANCH) || (state_q == S_JUMP));
  assign retireCnt  = retire_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)         retire_q <= '0;
    else if (retire_evt) retire_q <= retire_q + 1'b1;
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a trace-level model expands each instruction into the
// per-cycle outputs it must produce; a compare process checks the DUT every cycle.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcw, irw, mrd, mwr, rw;
    logic [1:0] pcsrc, asa, asb, rds;
    logic [2:0] aluop;
    logic       berr, ill;
  } outs_t;

  typedef struct packed {
    logic [3:0] op;
    logic       mr, zf;
    outs_t      exp;
  } cyc_t;

  logic       clk = 1'b0;
  logic       resetN;
  logic [3:0] opcode;
  logic       zeroFlag, memReady;
  logic       pcWrite, irWrite, memRead, memWrite, regWrite, busErr, illegalOp;
  logic [1:0] pcSrc, aluSrcA, aluSrcB, regDataSlct;
  logic [2:0] aluOp;
`ifdef CTRL_RETIRE_CNT_EN
  logic [15:0] retireCnt;
`endif

  int    tests = 0;
  int    fails = 0;
  int    model_retired = 0;
  bit    model_berr = 1'b0;
  cyc_t  stim_q[$];
  outs_t exp_q[$];
  outs_t dut_o;

  multicycle_ctrl dut (
    .clk(clk), .resetN(resetN), .opcode(opcode), .zeroFlag(zeroFlag), .memReady(memReady),
    .pcWrite(pcWrite), .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite),
    .regWrite(regWrite), .pcSrc(pcSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .regDataSlct(regDataSlct), .aluOp(aluOp), .busErr(busErr), .illegalOp(illegalOp)
`ifdef CTRL_RETIRE_CNT_EN
    , .retireCnt(retireCnt)
`endif
  );

  always #5 clk = ~clk;

  assign dut_o = {pcWrite, irWrite, memRead, memWrite, regWrite, pcSrc, aluSrcA, aluSrcB,
                  regDataSlct, aluOp, busErr, illegalOp};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outputs settle from state plus current inputs; sample mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      outs_t e;
      e = exp_q.pop_front();
      check("cycle_outs", 32'(dut_o), 32'(e));
    end
  end

  function automatic bit is_legal(input logic [3:0] op);
    return (op <= 4'h7) || (op == 4'hF);
  endfunction

  task automatic push(input logic [3:0] op, input logic mr, input logic zf, input outs_t e);
    cyc_t c;
    e.berr = model_berr;
    c.op = op; c.mr = mr; c.zf = zf; c.exp = e;
    stim_q.push_back(c);
  endtask

  // One instruction at the level of "what each cycle of it must look like".
  task automatic instr(input logic [3:0] op, input logic zf, input int fetch_waits,
                       input int mem_waits);
    outs_t e;
    for (int i = 0; i < fetch_waits; i++) begin
      e = '0; e.mrd = 1'b1; e.asb = 2'b01;
      push(op, 1'b0, zf, e);
    end
    e = '0; e.mrd = 1'b1; e.asb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
    push(op, 1'b1, zf, e);
    e = '0; e.asb = 2'b11; e.ill = !is_legal(op);
    push(op, 1'b1, zf, e);
    case (op)
      4'h0, 4'h1: begin
        e = '0; e.asa = 2'b01;
        if (op == 4'h0) e.aluop = 3'b010;
        else            e.asb = 2'b10;
        push(op, 1'b0, zf, e);
        e = '0; e.rw = 1'b1;
        push(op, 1'b0, zf, e);
      end
      4'h2, 4'h3: begin
        e = '0; e.asa = 2'b01; e.asb = 2'b10;
        push(op, 1'b0, zf, e);
        for (int i = 0; i <= mem_waits; i++) begin
          e = '0;
          if (op == 4'h2) e.mrd = 1'b1;
          else            e.mwr = 1'b1;
          push(op, (i == mem_waits), zf, e);
        end
        if (op == 4'h2) begin
          e = '0; e.rw = 1'b1; e.rds = 2'b01;
          push(op, 1'b0, zf, e);
        end
      end
      4'h4, 4'h5: begin
        e = '0; e.asa = 2'b01; e.aluop = 3'b001; e.pcsrc = 2'b01;
        e.pcw = (op == 4'h4) ? zf : !zf;
        push(op, 1'b1, zf, e);
      end
      4'h6, 4'h7: begin
        e = '0; e.pcw = 1'b1; e.pcsrc = 2'b10;
        if (op == 4'h7) begin e.rw = 1'b1; e.rds = 2'b10; end
        push(op, 1'b1, zf, e);
      end
      default: ;
    endcase
    if (op <= 4'h7) model_retired++;
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) push(4'hF, i[0], 1'b0, outs_t'(0));
  endtask

  task automatic fetch_timeout();
    outs_t e;
    for (int i = 0; i < 15; i++) begin
      e = '0; e.mrd = 1'b1; e.asb = 2'b01;
      push(4'h0, 1'b0, 1'b0, e);
    end
    model_berr = 1'b1;
  endtask

  task automatic run_stream();
    cyc_t c;
    while (stim_q.size() > 0) begin
      c = stim_q.pop_front();
      opcode = c.op; memReady = c.mr; zeroFlag = c.zf;
      exp_q.push_back(c.exp);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    resetN = 1'b0; opcode = 4'h0; zeroFlag = 1'b0; memReady = 1'b0;
    #2;
    check("reset_outs", 32'(dut_o), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    resetN = 1'b1;

    instr(4'h0, 1'b0, 0, 0);
    instr(4'h1, 1'b0, 0, 0);
    instr(4'h2, 1'b0, 0, 3);
    instr(4'h2, 1'b0, 14, 14);
    instr(4'h3, 1'b0, 1, 2);
    instr(4'h4, 1'b1, 0, 0);
    instr(4'h4, 1'b0, 0, 0);
    instr(4'h5, 1'b1, 0, 0);
    instr(4'h5, 1'b0, 0, 0);
    instr(4'h6, 1'b0, 0, 0);
    instr(4'h7, 1'b0, 0, 0);
    instr(4'h9, 1'b0, 0, 0);
    run_stream();
`ifdef CTRL_RETIRE_CNT_EN
    check("retire_cnt", 32'(retireCnt), 32'(model_retired));
    check("retire_cnt_lit", 32'(retireCnt), 32'd11);
`endif

    // Reset in the middle of a stalled load.
    opcode = 4'h2; memReady = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    memReady = 1'b0; #1;
    check("memrd_before_rst", 32'(memRead), 32'd1);
    resetN = 1'b0; #1;
    check("memrd_in_rst", 32'(memRead), 32'd0);
    check("outs_in_rst", 32'(dut_o), 32'd0);
    @(posedge clk); #1;
    resetN = 1'b1; #1;
    check("fetch_after_rst", 32'({memRead, irWrite, aluSrcB}), 32'b1001);
    @(posedge clk); #1;
    check("still_fetch", 32'(memRead), 32'd1);
`ifdef CTRL_RETIRE_CNT_EN
    check("retire_cnt_rst", 32'(retireCnt), 32'd0);
`endif

    // HALT parks the controller.
    instr(4'hF, 1'b0, 1, 0);
    halt_cycles(4);
    run_stream();

    // Fetch stall times out into HALT with a sticky bus error.
    resetN = 1'b0; @(posedge clk); #1; resetN = 1'b1;
    model_berr = 1'b0;
    fetch_timeout();
    halt_cycles(3);
    run_stream();
    check("bus_err_sticky", 32'(busErr), 32'd1);
    check("halt_no_req", 32'(memRead), 32'd0);
    resetN = 1'b0; #1;
    check("bus_err_cleared", 32'(busErr), 32'd0);
    @(posedge clk); #1; resetN = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
